hex_scan_display: RTL and testbench

//   Output-side counterpart of the Main result bus: takes the 32-bit HEX result word and drives an
//   8-digit multiplexed 7-segment display. It time-multiplexes one nibble per digit.
//   The word is double-buffered, so a new value only reaches the display at a frame boundary (no tearing).

---
 rtl/hex_disp_pkg.sv | 32 +++
 rtl/hex_to_seg7.sv | 11 +
 rtl/hex_scan_display.sv | 126 ++++++++++++
 tb/tb_hex_scan_display.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the scanned hex display: FSM state, blank pattern and
// the active-low hex-to-segment table (bit 0 = segment a ... bit 6 = segment g).
package hex_disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 15 first: entry k of the packed array is the pattern for hex digit k.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module hex_to_seg7
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/hex_scan_display.sv
// Multiplexed hex display driver; a new word is committed to the display only at a frame wrap.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero nibble.
module hex_scan_display
    import hex_disp_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

    state_t                 state_q, state_d;
    logic [PW-1:0]          presc_q;
    logic [DW-1:0]          digit_q;
    logic [DIGITS-1:0][3:0] shown_q, pending_q;
    logic                   pend_q, ready_q, ready_d, frame_q;
    logic [DIGITS-1:0]      an_q, an_d;
    logic [6:0]             seg_q, seg_d, seg_raw;
    logic                   lit, transfer, tick, wrap;

    assign transfer = valid_i & ready_q;
    assign tick     = (presc_q == PRESC_LAST);
    assign wrap     = (state_q == SCAN) & tick & (digit_q == DIGIT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= BLANK;
        else      state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (state_q == BLANK && transfer) state_d = SCAN;
    end

    // NOTE: shown/pending are reset too, so a value accepted before reset can never resurface.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= '0;
            digit_q   <= '0;
            shown_q   <= '0;
            pending_q <= '0;
            pend_q    <= 1'b0;
            ready_q   <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            frame_q <= wrap;
            ready_q <= ready_d;
            if (state_q == BLANK) begin
                if (transfer) shown_q <= data_i;
            end else begin
                presc_q <= tick ? '0 : presc_q + 1'b1;
                if (tick) digit_q <= (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
                if (wrap && pend_q) begin
                    shown_q <= pending_q;
                    pend_q  <= 1'b0;
                end
                // A transfer can only happen with nothing pending, so it never races the commit above.
                if (transfer) begin
                    pending_q <= data_i;
                    pend_q    <= 1'b1;
                end
            end
        end
    end

    hex_to_seg7 u_dec (
        .nibble (shown_q[digit_q]),
        .seg    (seg_raw)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [DW-1:0] msd;

    always_comb begin
        msd = '0;
        for (int k = 1; k < DIGITS; k++)
            if (shown_q[k] != 4'h0) msd = DW'(k);
    end

    assign lit = (digit_q <= msd);
`else
    assign lit = 1'b1;
`endif

    // Ready reopens the cycle after the pending word has been committed at a wrap.
    always_comb begin
        an_d    = '1;
        seg_d   = SEG_BLANK;
        ready_d = 1'b1;
        if (state_q == SCAN) begin
            an_d    = ~(DIGITS'(1) << digit_q);
            seg_d   = lit ? seg_raw : SEG_BLANK;
            ready_d = ~(transfer | pend_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign ready_o = ready_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display (DIGITS=8, PRESCALE=4): stimulus queues cycle-tagged
// expectations, a negedge monitor compares and retires them.
module tb_hex_scan_display;

    typedef struct {
        int         at;
        logic [7:0] an;
        logic [6:0] seg;
        logic       ready;
        logic       frame;
    } exp_t;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [6:0]  seg_o;
    logic [7:0]  an_o;
    logic        frame_o;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    timeouts = 0;
    bit    done = 1'b0;
    exp_t  sb[$];
    string sb_name[$];

    hex_scan_display #(
        .DIGITS   (8),
        .PRESCALE (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .seg_o   (seg_o),
        .an_o    (an_o),
        .frame_o (frame_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int at, input logic [7:0] an, input logic [6:0] seg,
                        input logic rdy, input logic frm, input string name);
        exp_t e;
        e.at    = at;
        e.an    = an;
        e.seg   = seg;
        e.ready = rdy;
        e.frame = frm;
        sb.push_back(e);
        sb_name.push_back(name);
    endtask

    // Called at a negedge with valid_i high; returns the cycle of the accepting edge.
    task automatic wait_accept(output int t);
        int budget;
        budget = 200;
        t = -1;
        while (budget > 0) begin
            if (ready_o === 1'b1) begin
                t = cyc + 1;
                return;
            end
            @(negedge clk);
            budget--;
        end
        timeouts++;
    endtask

    // Monitor: retire every expectation tagged for this cycle; finish once stimulus is done.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                n_checks++;
                if (an_o !== sb[i].an || seg_o !== sb[i].seg ||
                    ready_o !== sb[i].ready || frame_o !== sb[i].frame) begin
                    n_fail++;
                    $display("FAIL %s @cycle %0d: got an=%h seg=%b ready=%b frame=%b, want an=%h seg=%b ready=%b frame=%b",
                             sb_name[i], cyc, an_o, seg_o, ready_o, frame_o,
                             sb[i].an, sb[i].seg, sb[i].ready, sb[i].frame);
                end
                sb.delete(i);
                sb_name.delete(i);
            end
        end
        if (done || cyc > 4000) begin
            n_checks++;
            if (!done || sb.size() != 0 || timeouts != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d unreached expectations, %0d timeouts, finished=%0d; want 0, 0, 1",
                         sb.size(), timeouts, done);
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        int b;
        int t;

        // 1. Held in reset with valid_i high: dark, ready, no frame.
        rst     = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'hDEAD_BEEF;
        for (int i = 1; i <= 10; i++) push(i, 8'hFF, 7'h7F, 1'b1, 1'b0, "reset_hold");
        repeat (10) @(negedge clk);
        rst     = 1'b1;
        valid_i = 1'b0;
        push(cyc + 4, 8'hFF, 7'h7F, 1'b1, 1'b0, "blank_idle");
        repeat (5) @(negedge clk);

        // 2. First value 5: digit 0 lit two cycles after the handshake, frame every 32 cycles.
        data_i  = 32'h0000_0005;
        valid_i = 1'b1;
        wait_accept(b);
        push(b,      8'hFF, 7'h7F,      1'b1, 1'b0, "first_latency");
        push(b + 1,  8'hFE, 7'b0010010, 1'b1, 1'b0, "load5_d0");
        push(b + 5,  8'hFD, 7'b1000000, 1'b1, 1'b0, "load5_d1");
        push(b + 29, 8'h7F, 7'b1000000, 1'b1, 1'b0, "load5_d7");
        push(b + 32, 8'h7F, 7'b1000000, 1'b1, 1'b1, "frame1");
        push(b + 33, 8'hFE, 7'b0010010, 1'b1, 1'b0, "post_frame1");
        @(negedge clk);
        valid_i = 1'b0;
        repeat (39) @(negedge clk);

        // 3/4. Mid-frame load of 1234_5678, then new data offered while ready_o is low.
        data_i  = 32'h1234_5678;
        valid_i = 1'b1;
        push(b + 40, 8'hFD, 7'b1000000, 1'b0, 1'b0, "ready_drop");
        push(b + 49, 8'hEF, 7'b1000000, 1'b0, 1'b0, "old_value_shown");
        push(b + 64, 8'h7F, 7'b1000000, 1'b0, 1'b1, "frame2_old_value");
        push(b + 65, 8'hFE, 7'b0000000, 1'b1, 1'b0, "new_d0_ready");
        push(b + 70, 8'hFD, 7'b1111000, 1'b1, 1'b0, "ignored_ready_high");
        push(b + 77, 8'hF7, 7'b0010010, 1'b1, 1'b0, "new_d3");
        push(b + 93, 8'h7F, 7'b1111001, 1'b1, 1'b0, "new_d7");
        push(b + 97, 8'hFE, 7'b0000000, 1'b1, 1'b0, "ignored_not_shown");
        @(negedge clk);
        data_i = 32'hAAAA_AAAA;
        repeat (20) @(negedge clk);
        valid_i = 1'b0;
        repeat (40) @(negedge clk);

        // 4. Source holds valid_i through ready_o low: 0E00 is taken once ready_o returns.
        data_i  = 32'h0000_00C0;
        valid_i = 1'b1;
        push(b + 101, 8'hFD, 7'b1111000, 1'b0, 1'b0, "c0_pending");
        push(b + 128, 8'h7F, 7'b1111001, 1'b0, 1'b1, "frame4");
        push(b + 129, 8'hFE, 7'b1000000, 1'b1, 1'b0, "c0_d0");
        push(b + 133, 8'hFD, 7'b1000110, 1'b0, 1'b0, "held_c0_d1");
        push(b + 160, 8'h7F, LZ,         1'b0, 1'b1, "frame5");
        push(b + 165, 8'hFD, 7'b1000000, 1'b1, 1'b0, "lzb_inner_zero");
        push(b + 169, 8'hFB, 7'b0000110, 1'b1, 1'b0, "e00_d2");
        push(b + 173, 8'hF7, LZ,         1'b1, 1'b0, "lzb_d3");
        @(negedge clk);
        data_i = 32'h0000_0E00;
        wait_accept(t);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (45) @(negedge clk);

        // 5. Value 0: digit 0 always shows "0"; upper digits depend on leading-zero blanking.
        data_i  = 32'h0000_0000;
        valid_i = 1'b1;
        push(b + 176, 8'hF7, LZ,         1'b0, 1'b0, "zero_pending");
        push(b + 192, 8'h7F, LZ,         1'b0, 1'b1, "frame6");
        push(b + 193, 8'hFE, 7'b1000000, 1'b1, 1'b0, "zero_d0");
        push(b + 213, 8'hDF, LZ,         1'b1, 1'b0, "zero_d5");
        push(b + 224, 8'h7F, LZ,         1'b1, 1'b1, "frame7");
        push(b + 237, 8'hF7, LZ,         1'b1, 1'b0, "pre_reset_d3");
        push(b + 238, 8'hFF, 7'h7F,      1'b1, 1'b0, "async_dark");
        @(negedge clk);
        valid_i = 1'b0;
        repeat (61) @(negedge clk);

        // 6. Reset asserted between clock edges while digit 3 is lit.
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b1;
        valid_i = 1'b0;
        push(cyc + 6,  8'hFF, 7'h7F, 1'b1, 1'b0, "blank_after_reset");
        push(cyc + 41, 8'hFF, 7'h7F, 1'b1, 1'b0, "blank_long");
        repeat (45) @(negedge clk);

        data_i  = 32'hF000_0007;
        valid_i = 1'b1;
        wait_accept(t);
        push(t + 1,  8'hFE, 7'b1111000, 1'b1, 1'b0, "final_d0");
        push(t + 29, 8'h7F, 7'b0001110, 1'b1, 1'b0, "final_d7_f");
        push(t + 32, 8'h7F, 7'b0001110, 1'b1, 1'b1, "final_frame");
        @(negedge clk);
        valid_i = 1'b0;
        repeat (35) @(negedge clk);
        done = 1'b1;
    end

endmodule
